// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI4 read channel (AR/R) between instruction fetch (IF) and the
//   data-memory load path (MEM). Requests are held levels. Simultaneous requests
//   are resolved round-robin. Each grant issues one single-beat read, and the
//   data returns to the owner as a one-cycle rvalid pulse. At most one
//   transaction is outstanding.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req_i/addr_i/size_i        IF read request (held until if_rvalid_o)
//   if_rvalid_o/rdata_o/rerr_o    IF response pulse, data and error flag
//   mem_*                         same set of signals for the MEM load path
//   axi_ar_*                      AXI4 read-address channel (master side)
//   axi_r_*                       AXI4 read-data channel (master side)
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic [2:0]        if_size_i,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_rerr_o,
  // data-memory load path
  input  logic              mem_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [2:0]        mem_size_i,
  output logic              mem_rvalid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_rerr_o,
  // AXI read address channel
  output logic              axi_ar_valid_o,
  input  logic              axi_ar_ready_i,
  output logic [ADDR_W-1:0] axi_ar_addr_o,
  output logic [ID_W-1:0]   axi_ar_id_o,
  output logic [7:0]        axi_ar_len_o,
  output logic [2:0]        axi_ar_size_o,
  output logic [1:0]        axi_ar_burst_o,
  output logic              axi_ar_lock_o,
  output logic [3:0]        axi_ar_cache_o,
  output logic [2:0]        axi_ar_prot_o,
  output logic [3:0]        axi_ar_qos_o,
  output logic [3:0]        axi_ar_region_o,
  output logic [USER_W-1:0] axi_ar_user_o,
  // AXI read data channel
  output logic              axi_r_ready_o,
  input  logic              axi_r_valid_i,
  input  logic [1:0]        axi_r_resp_i,
  input  logic [DATA_W-1:0] axi_r_data_i,
  input  logic              axi_r_last_i,
  input  logic [ID_W-1:0]   axi_r_id_i,
  input  logic [USER_W-1:0] axi_r_user_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, last_gnt, winner;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [ID_W-1:0]   issued_id;
  logic              any_req;
  logic              r_done;
  logic              unused_r_user;

  assign unused_r_user = ^axi_r_user_i;

  assign any_req = if_req_i | mem_req_i;
  // MEM wins when it is alone, or on a tie when IF was granted last.
  assign winner  = (mem_req_i && (!if_req_i || last_gnt == OWN_IF)) ? OWN_MEM : OWN_IF;
  // The AR id doubles as the owner tag; the R id is checked against it.
  assign issued_id = (owner == OWN_MEM) ? ID_W'(1) : '0;
  // Non-last beats are accepted but only the last one carries the result.
  assign r_done    = axi_r_valid_i & axi_r_last_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)        state_nxt = ADDR;
      ADDR:    if (axi_ar_ready_i) state_nxt = DATA;
      DATA:    if (r_done)         state_nxt = RESP;
      RESP:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= OWN_IF;
      last_gnt <= OWN_MEM;   // so the first tie after reset goes to IF
      addr_q   <= '0;
      size_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      // Requests are only looked at in IDLE; the AR payload is frozen after.
      if (state == IDLE && any_req) begin
        owner    <= winner;
        last_gnt <= winner;
        addr_q   <= (winner == OWN_MEM) ? mem_addr_i : if_addr_i;
        size_q   <= (winner == OWN_MEM) ? mem_size_i : if_size_i;
      end
      if (state == DATA && r_done) begin
        data_q <= axi_r_data_i;
        err_q  <= (axi_r_resp_i != 2'b00) | (axi_r_id_i != issued_id);
      end
    end
  end

  // Handshake outputs decode the state register only.
  assign axi_ar_valid_o  = (state == ADDR);
  assign axi_ar_addr_o   = addr_q;
  assign axi_ar_id_o     = issued_id;
  assign axi_ar_size_o   = size_q;
  assign axi_ar_len_o    = 8'd0;
  assign axi_ar_burst_o  = 2'b01;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = 4'b0010;
  assign axi_ar_prot_o   = 3'b000;
  assign axi_ar_qos_o    = 4'd0;
  assign axi_ar_region_o = 4'd0;
  assign axi_ar_user_o   = '0;

  assign axi_r_ready_o   = (state == DATA);

  // Data and error are gated so the non-owner always sees zeros.
  assign if_rvalid_o  = (state == RESP) && (owner == OWN_IF);
  assign mem_rvalid_o = (state == RESP) && (owner == OWN_MEM);
  assign if_rdata_o   = if_rvalid_o  ? data_q : '0;
  assign mem_rdata_o  = mem_rvalid_o ? data_q : '0;
  assign if_rerr_o    = if_rvalid_o  & err_q;
  assign mem_rerr_o   = mem_rvalid_o & err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Self-checking bench for axi_rd_arbiter. The bench plays the AXI slave,
//   pushes the expected response whenever it drives a last R beat, and a
//   monitor pops and compares every rvalid pulse.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_i, mem_req_i;
  logic [31:0] if_addr_i, mem_addr_i;
  logic [2:0]  if_size_i, mem_size_i;
  logic        if_rvalid_o, mem_rvalid_o;
  logic [63:0] if_rdata_o, mem_rdata_o;
  logic        if_rerr_o, mem_rerr_o;
  logic        axi_ar_valid_o, axi_ar_ready_i;
  logic [31:0] axi_ar_addr_o;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;
  logic        axi_ar_lock_o;
  logic [3:0]  axi_ar_cache_o;
  logic [2:0]  axi_ar_prot_o;
  logic [3:0]  axi_ar_qos_o;
  logic [3:0]  axi_ar_region_o;
  logic [0:0]  axi_ar_user_o;
  logic        axi_r_ready_o, axi_r_valid_i, axi_r_last_i;
  logic [1:0]  axi_r_resp_i;
  logic [63:0] axi_r_data_i;
  logic [3:0]  axi_r_id_i;
  logic [0:0]  axi_r_user_i;

  axi_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_size_i(if_size_i),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_rerr_o(if_rerr_o),
    .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_size_i(mem_size_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_rerr_o(mem_rerr_o),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_id_o(axi_ar_id_o),
    .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
    .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_lock_o(axi_ar_lock_o),
    .axi_ar_cache_o(axi_ar_cache_o), .axi_ar_prot_o(axi_ar_prot_o),
    .axi_ar_qos_o(axi_ar_qos_o), .axi_ar_region_o(axi_ar_region_o),
    .axi_ar_user_o(axi_ar_user_o),
    .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i),
    .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i),
    .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i),
    .axi_r_user_i(axi_r_user_i)
  );

  typedef struct {
    bit          is_mem;
    logic [63:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // Response monitor: every rvalid pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid_o === 1'b1 || mem_rvalid_o === 1'b1) begin
        vectors++;
        if (if_rvalid_o === 1'b1 && mem_rvalid_o === 1'b1) begin
          miscompares++;
          $display("FAIL resp_both: got if=1 mem=1 required one owner");
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected: got if=%0b mem=%0b required no pulse", if_rvalid_o, mem_rvalid_o);
        end else begin
          e = sb.pop_front();
          if (e.is_mem) begin
            if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== e.data || mem_rerr_o !== e.err ||
                if_rdata_o !== 64'd0 || if_rerr_o !== 1'b0) begin
              miscompares++;
              $display("FAIL resp_mem: got rv=%0b data=%h err=%0b if_data=%h required rv=1 data=%h err=%0b if_data=0",
                       mem_rvalid_o, mem_rdata_o, mem_rerr_o, if_rdata_o, e.data, e.err);
            end
          end else begin
            if (if_rvalid_o !== 1'b1 || if_rdata_o !== e.data || if_rerr_o !== e.err ||
                mem_rdata_o !== 64'd0 || mem_rerr_o !== 1'b0) begin
              miscompares++;
              $display("FAIL resp_if: got rv=%0b data=%h err=%0b mem_data=%h required rv=1 data=%h err=%0b mem_data=0",
                       if_rvalid_o, if_rdata_o, if_rerr_o, mem_rdata_o, e.data, e.err);
            end
          end
        end
      end
    end
  end

  // AXI slave driver. Returns the AR payload seen, whether it stayed stable
  // while valid was high, and whether the channel behaved (one AR handshake,
  // r_ready high while the bench waits). Ends on the negedge of the RESP cycle.
  task automatic axi_serve(input int ar_wait, input int r_wait, input int pre_beats,
                           input logic [63:0] data, input logic [1:0] resp,
                           input logic [3:0] rid,
                           output logic [31:0] a, output logic [3:0] id,
                           output logic [2:0] sz, output logic [7:0] len,
                           output bit stable, output bit chan_ok, output bit timeout);
    int n = 0;
    stable = 1'b1; chan_ok = 1'b1; timeout = 1'b0;
    a = '0; id = '0; sz = '0; len = '0;
    while (axi_ar_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (axi_ar_valid_o !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    a = axi_ar_addr_o; id = axi_ar_id_o; sz = axi_ar_size_o; len = axi_ar_len_o;
    repeat (ar_wait) begin
      @(negedge clk);
      if (axi_ar_valid_o !== 1'b1 || axi_ar_addr_o !== a || axi_ar_id_o !== id ||
          axi_ar_size_o !== sz || axi_ar_len_o !== len) stable = 1'b0;
    end
    axi_ar_ready_i = 1'b1;
    @(negedge clk);
    axi_ar_ready_i = 1'b0;
    repeat (r_wait) begin
      if (axi_ar_valid_o !== 1'b0 || axi_r_ready_o !== 1'b1) chan_ok = 1'b0;
      @(negedge clk);
    end
    repeat (pre_beats) begin
      if (axi_ar_valid_o !== 1'b0 || axi_r_ready_o !== 1'b1) chan_ok = 1'b0;
      axi_r_valid_i = 1'b1; axi_r_last_i = 1'b0;
      axi_r_data_i  = 64'hdead_beef_dead_beef; axi_r_resp_i = 2'b00; axi_r_id_i = rid;
      @(negedge clk);
    end
    if (axi_ar_valid_o !== 1'b0 || axi_r_ready_o !== 1'b1) chan_ok = 1'b0;
    axi_r_valid_i = 1'b1; axi_r_last_i = 1'b1;
    axi_r_data_i  = data; axi_r_resp_i = resp; axi_r_id_i = rid;
    @(negedge clk);
    axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0;
    axi_r_data_i  = '0; axi_r_resp_i = '0; axi_r_id_i = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({axi_ar_valid_o, axi_r_ready_o, if_rvalid_o, mem_rvalid_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_handshakes: got %b required 0000",
               {axi_ar_valid_o, axi_r_ready_o, if_rvalid_o, mem_rvalid_o});
    end
    vectors++;
    if ({if_rerr_o, mem_rerr_o} !== 2'b00 || if_rdata_o !== 64'd0 || mem_rdata_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_resp: got err=%b if_data=%h mem_data=%h required zeros",
               {if_rerr_o, mem_rerr_o}, if_rdata_o, mem_rdata_o);
    end
    vectors++;
    if (axi_ar_addr_o !== 32'd0 || axi_ar_id_o !== 4'd0 || axi_ar_size_o !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ar: got addr=%h id=%0d size=%0d required 0 0 0",
               axi_ar_addr_o, axi_ar_id_o, axi_ar_size_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_if();
    logic [31:0] a; logic [3:0] id; logic [2:0] sz; logic [7:0] len;
    bit stable, chan_ok, timeout;
    time t0;
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000; if_size_i = 3'd2;
    t0 = $time;
    sb.push_back('{is_mem: 1'b0, data: 64'h0000_0013_0000_0093, err: 1'b0});
    axi_serve(0, 0, 0, 64'h0000_0013_0000_0093, 2'b00, 4'd0, a, id, sz, len, stable, chan_ok, timeout);
    vectors++;
    if (timeout || a !== 32'h8000_0000 || id !== 4'd0 || len !== 8'd0 || sz !== 3'd2) begin
      miscompares++;
      $display("FAIL single_ar: got to=%0b addr=%h id=%0d len=%0d size=%0d required addr=80000000 id=0 len=0 size=2",
               timeout, a, id, len, sz);
    end
    vectors++;
    if ({axi_ar_burst_o, axi_ar_lock_o, axi_ar_cache_o, axi_ar_prot_o, axi_ar_qos_o,
         axi_ar_region_o, axi_ar_user_o} !== {2'b01, 1'b0, 4'b0010, 3'b000, 4'd0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_const: got burst=%b lock=%b cache=%b prot=%b qos=%h region=%h user=%b",
               axi_ar_burst_o, axi_ar_lock_o, axi_ar_cache_o, axi_ar_prot_o, axi_ar_qos_o,
               axi_ar_region_o, axi_ar_user_o);
    end
    vectors++;
    if (if_rvalid_o !== 1'b1 || mem_rvalid_o !== 1'b0 || ($time - t0) != 30) begin
      miscompares++;
      $display("FAIL single_latency: got if_rv=%0b mem_rv=%0b after %0t required 1 0 after 30",
               if_rvalid_o, mem_rvalid_o, $time - t0);
    end
    if_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (if_rvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse_len: got if_rv=%0b required 0", if_rvalid_o);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a; logic [3:0] id; logic [2:0] sz; logic [7:0] len;
    bit stable, chan_ok, timeout;
    bit exp_mem;
    apply_reset();
    if_req_i  = 1'b1; if_addr_i  = 32'h8000_0000; if_size_i  = 3'd2;
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_1000; mem_size_i = 3'd3;
    for (int k = 0; k < 4; k++) begin
      exp_mem = (k % 2 == 1);
      sb.push_back('{is_mem: exp_mem, data: 64'h1111_0000_0000_0000 + 64'(k), err: 1'b0});
      axi_serve(0, 1, 0, 64'h1111_0000_0000_0000 + 64'(k), 2'b00, exp_mem ? 4'd1 : 4'd0,
                a, id, sz, len, stable, chan_ok, timeout);
      vectors++;
      if (timeout || a !== (exp_mem ? 32'h8000_1000 : 32'h8000_0000) ||
          id !== (exp_mem ? 4'd1 : 4'd0) || sz !== (exp_mem ? 3'd3 : 3'd2)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got to=%0b addr=%h id=%0d size=%0d required %s",
                 k, timeout, a, id, sz, exp_mem ? "MEM" : "IF");
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] a; logic [3:0] id; logic [2:0] sz; logic [7:0] len;
    bit stable, chan_ok, timeout;
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_0040; mem_size_i = 3'd1;
    sb.push_back('{is_mem: 1'b1, data: 64'h0123_4567_89ab_cdef, err: 1'b0});
    axi_serve(5, 7, 1, 64'h0123_4567_89ab_cdef, 2'b00, 4'd1, a, id, sz, len, stable, chan_ok, timeout);
    vectors++;
    if (timeout || !stable || a !== 32'h8000_0040 || id !== 4'd1 || sz !== 3'd1) begin
      miscompares++;
      $display("FAIL bp_ar_stable: got to=%0b stable=%0b addr=%h id=%0d size=%0d required stable MEM payload",
               timeout, stable, a, id, sz);
    end
    vectors++;
    if (!chan_ok) begin
      miscompares++;
      $display("FAIL bp_channel: got chan_ok=0 required one AR handshake and r_ready held");
    end
    vectors++;
    if (mem_rvalid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resp_timing: got mem_rv=%0b required 1", mem_rvalid_o);
    end
    mem_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_error();
    logic [31:0] a; logic [3:0] id; logic [2:0] sz; logic [7:0] len;
    bit stable, chan_ok, timeout;
    logic [1:0] resp_tab[2] = '{2'b10, 2'b00};
    logic [3:0] rid_tab[2]  = '{4'd1, 4'd0};
    mem_addr_i = 32'h8000_2000; mem_size_i = 3'd3;
    for (int k = 0; k < 2; k++) begin
      mem_req_i = 1'b1;
      sb.push_back('{is_mem: 1'b1, data: 64'hee00 + 64'(k), err: 1'b1});
      axi_serve(1, 0, 0, 64'hee00 + 64'(k), resp_tab[k], rid_tab[k], a, id, sz, len, stable, chan_ok, timeout);
      vectors++;
      if (timeout || mem_rerr_o !== 1'b1) begin
        miscompares++;
        $display("FAIL err_case%0d: got to=%0b mem_rerr=%0b required 1", k, timeout, mem_rerr_o);
      end
      mem_req_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; logic [3:0] id; logic [2:0] sz; logic [7:0] len;
    bit stable, chan_ok, timeout;
    int n = 0;
    int bad = 0;
    if_req_i = 1'b1; if_addr_i = 32'h8000_0100; if_size_i = 3'd2;
    while (axi_ar_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    axi_ar_ready_i = 1'b1;
    @(negedge clk);
    axi_ar_ready_i = 1'b0;
    vectors++;
    if (axi_r_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_in_data: got r_ready=%0b required 1", axi_r_ready_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({axi_ar_valid_o, axi_r_ready_o, if_rvalid_o, mem_rvalid_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid_drop: got %b required 0000",
               {axi_ar_valid_o, axi_r_ready_o, if_rvalid_o, mem_rvalid_o});
    end
    if_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (if_rvalid_o !== 1'b0 || mem_rvalid_o !== 1'b0 || axi_ar_valid_o !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: got %0d active cycles required 0", bad);
    end
    if_req_i  = 1'b1; if_addr_i  = 32'h8000_0200; if_size_i  = 3'd2;
    mem_req_i = 1'b1; mem_addr_i = 32'h8000_3000; mem_size_i = 3'd3;
    sb.push_back('{is_mem: 1'b0, data: 64'h5a5a_5a5a_5a5a_5a5a, err: 1'b0});
    axi_serve(0, 0, 0, 64'h5a5a_5a5a_5a5a_5a5a, 2'b00, 4'd0, a, id, sz, len, stable, chan_ok, timeout);
    vectors++;
    if (timeout || id !== 4'd0 || a !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL rst_mid_tie: got to=%0b id=%0d addr=%h required IF id=0 addr=80000200",
               timeout, id, a);
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0; if_size_i = '0;
    mem_req_i = 1'b0; mem_addr_i = '0; mem_size_i = '0;
    axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0;
    axi_r_resp_i = '0; axi_r_data_i = '0; axi_r_id_i = '0; axi_r_user_i = '0;
    @(negedge clk);
    test_reset();
    test_single_if();
    test_round_robin();
    test_backpressure();
    test_error();
    test_reset_mid();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending responses required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
